svm_seq_mac: RTL and testbench

SVM_SEQ_MAC -- requirements
Module: svm_seq_mac

---
 rtl/svm_seq_mac_if.sv | 27 ++
 rtl/svm_seq_mac.sv | 125 ++++++++++++
 tb/tb_svm_seq_mac.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_seq_mac_if.sv
// Handshake and data bundle between the pairwise-class picker (master) and
// the sequential SVM multiply-accumulate engine (slave).
interface svm_seq_mac_if #(
    parameter int N_features   = 34,
    parameter int featureWidth = 4,
    parameter int weightWidth  = 8,
    parameter int biasWidth    = 16
);
    logic                               start;
    logic [featureWidth*N_features-1:0] features;
    logic [weightWidth*N_features-1:0]  weight;
    logic [biasWidth-1:0]               bia;
    logic                               stop;
    logic                               svmready;
    logic                               w_class;
    logic                               busy;

    modport master (
        output start, features, weight, bia, stop,
        input  svmready, w_class, busy
    );

    modport slave (
        input  start, features, weight, bia, stop,
        output svmready, w_class, busy
    );
endinterface

// File: rtl/svm_seq_mac.sv
// Sequential linear-SVM decision engine: one feature*weight product per cycle,
// then the bias, then a one-cycle svmready strobe carrying the sign of the score.
module svm_seq_mac #(
    parameter int N_features   = 34,
    parameter int featureWidth = 4,
    parameter int weightWidth  = 8,
    parameter int biasWidth    = 16,
    parameter int accWidth     = 20
) (
    input logic         clk,
    input logic         rst_n,
    svm_seq_mac_if.slave bus
);
    localparam int PROD_W = featureWidth + 1 + weightWidth;
    localparam int IDX_W  = (N_features > 1) ? $clog2(N_features) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_features - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_BIAS = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                             state_q;
    logic [featureWidth*N_features-1:0] feat_q;
    logic signed [accWidth-1:0]         acc_q;
    logic [IDX_W-1:0]                   idx_q;
    logic                               svmready_q;
    logic                               w_class_q;
    logic                               busy_q;

    logic [featureWidth-1:0]            feat_s;
    logic [weightWidth-1:0]             wgt_s;
    logic signed [PROD_W-1:0]           feat_ext_s;
    logic signed [PROD_W-1:0]           wgt_ext_s;
    logic signed [PROD_W-1:0]           prod_s;
    logic signed [accWidth-1:0]         term_s;
    logic signed [accWidth-1:0]         bias_ext_s;
    logic signed [accWidth-1:0]         mac_sum_d;
    logic signed [accWidth-1:0]         bias_sum_d;
    logic                               score_pos_d;

    // Current lane product and the two candidate accumulator sums.
    always_comb begin
        feat_s      = feat_q[int'(idx_q)*featureWidth +: featureWidth];
        wgt_s       = bus.weight[int'(idx_q)*weightWidth +: weightWidth];
        // Feature is unsigned: a zero sign bit keeps it positive in the signed product.
        feat_ext_s  = {{(PROD_W-featureWidth){1'b0}}, feat_s};
        wgt_ext_s   = {{(PROD_W-weightWidth){wgt_s[weightWidth-1]}}, wgt_s};
        prod_s      = feat_ext_s * wgt_ext_s;
        term_s      = {{(accWidth-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        bias_ext_s  = {{(accWidth-biasWidth){bus.bia[biasWidth-1]}}, bus.bia};
        mac_sum_d   = acc_q + term_s;
        bias_sum_d  = acc_q + bias_ext_s;
        score_pos_d = (!bias_sum_d[accWidth-1]) && (bias_sum_d != '0);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            feat_q     <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            svmready_q <= 1'b0;
            w_class_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    svmready_q <= 1'b0;
                    if (bus.start) begin
                        feat_q  <= bus.features;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_MAC: begin
                    svmready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    acc_q      <= mac_sum_d;
                    if (idx_q == IDX_LAST) begin
                        state_q <= S_BIAS;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                S_BIAS: begin
                    acc_q      <= bias_sum_d;
                    w_class_q  <= score_pos_d;
                    svmready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    svmready_q <= 1'b0;
                    if (bus.stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Next pair of the picker reuses the latched feature vector.
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                default: begin
                    svmready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.svmready = svmready_q;
    assign bus.w_class  = w_class_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_svm_seq_mac.sv
// Self-checking bench for svm_seq_mac: directed scenarios plus randomized
// chained decisions, compared every cycle against a cycle-scheduled score model.
module tb_svm_seq_mac;
    localparam int N   = 4;
    localparam int FW  = 4;
    localparam int WW  = 8;
    localparam int BW  = 16;
    localparam int AW  = 20;
    localparam int LAT = N + 2;

    typedef logic [FW*N-1:0] fvec_t;
    typedef logic [WW*N-1:0] wvec_t;
    typedef logic [BW-1:0]   bvec_t;
    typedef struct { int cyc; bit w; } exp_t;

    logic clk;
    logic rst_n;
    svm_seq_mac_if #(.N_features(N), .featureWidth(FW), .weightWidth(WW), .biasWidth(BW)) bus_if ();

    svm_seq_mac #(.N_features(N), .featureWidth(FW), .weightWidth(WW),
                  .biasWidth(BW), .accWidth(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    exp_t  exp_q[$];
    bit    held_w = 1'b0;
    int    busy_from = 0;
    int    busy_to   = -1;
    int    last_ready_cyc = -1;
    int    last_ready_w   = -1;
    wvec_t wq[8];
    bvec_t bq[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Score = bias + sum(feature_i * weight_i), plain integer arithmetic.
    function automatic int model_score(input fvec_t f, input wvec_t w, input bvec_t b);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < N; i++)
            s += int'(f[i*FW +: FW]) * int'($signed(w[i*WW +: WW]));
        return s;
    endfunction

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clk) begin
        bit exp_rdy;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        exp_rdy = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (exp_rdy) begin
            held_w = exp_q[0].w;
            void'(exp_q.pop_front());
        end
        check("svmready", int'(bus_if.svmready), int'(exp_rdy));
        check("w_class", int'(bus_if.w_class), int'(held_w));
        check("busy", int'(bus_if.busy), int'(cyc >= busy_from && cyc <= busy_to));
        if (bus_if.svmready === 1'b1) begin
            last_ready_cyc = cyc;
            last_ready_w   = int'(bus_if.w_class);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_chain(input fvec_t f, input int n_dec, input bit noise,
                             input int inj_rel, output int c0);
        exp_t e;
        c0 = cyc;
        bus_if.features = f;
        bus_if.weight   = wq[0];
        bus_if.bia      = bq[0];
        bus_if.start    = 1'b1;
        bus_if.stop     = 1'b0;
        busy_from = c0 + 1;
        busy_to   = c0 + n_dec * LAT;
        for (int k = 0; k < n_dec; k++) begin
            e.cyc = c0 + (k + 1) * LAT;
            e.w   = model_score(f, wq[k], bq[k]) > 0;
            exp_q.push_back(e);
        end
        for (int rel = 1; rel <= n_dec * LAT; rel++) begin
            next_cycle();
            bus_if.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus_if.features = fvec_t'($urandom);
            if (rel == inj_rel) begin
                bus_if.start    = 1'b1;
                bus_if.features = ~f;
            end
            if (rel % LAT == 0) begin
                bus_if.stop = (rel == n_dec * LAT);
                if (noise) begin
                    bus_if.weight = wvec_t'($urandom);
                    bus_if.bia    = bvec_t'($urandom);
                end
            end else begin
                bus_if.stop = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (rel % LAT == 1 && rel > 1) begin
                    bus_if.weight = wq[rel / LAT];
                    bus_if.bia    = bq[rel / LAT];
                end
            end
        end
        next_cycle();
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
    endtask

    task automatic reset_mid_op();
        exp_t e;
        int   c0;
        c0 = cyc;
        bus_if.features = 16'h1111;
        bus_if.weight   = 32'h04030201;
        bus_if.bia      = 16'hFFF7;
        bus_if.start    = 1'b1;
        busy_from = c0 + 1;
        busy_to   = c0 + LAT;
        e.cyc = c0 + LAT;
        e.w   = 1'b1;
        exp_q.push_back(e);
        next_cycle();
        bus_if.start = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        exp_q.delete();
        held_w  = 1'b0;
        busy_to = -1;
        #1;
        check("rst_svmready", int'(bus_if.svmready), 0);
        check("rst_w_class", int'(bus_if.w_class), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    c0;
        int    nd;
        fvec_t f;
        rst_n = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        bus_if.features = '0;
        bus_if.weight   = '0;
        bus_if.bia      = '0;

        check("model_pin_pos", model_score(16'h1111, 32'h04030201, 16'hFFF7), 1);
        check("model_pin_zero", model_score(16'h1111, 32'h04030201, 16'hFFF6), 0);
        check("model_pin_ext", model_score(16'hFFFF, 32'h80808080, 16'h8000), -40448);

        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // Single decision, positive score.
        wq[0] = 32'h04030201; bq[0] = 16'hFFF7;
        run_chain(16'h1111, 1, 1'b0, -1, c0);
        check("lat_single", last_ready_cyc - c0, LAT);
        check("w_single_pos", last_ready_w, 1);

        // Extreme values must not wrap.
        wq[0] = 32'h80808080; bq[0] = 16'h8000;
        run_chain(16'hFFFF, 1, 1'b0, -1, c0);
        check("w_extreme", last_ready_w, 0);

        wq[0] = 32'h04030201; bq[0] = 16'hFFF7;
        run_chain(16'h1111, 1, 1'b0, -1, c0);
        check("w_single_pos2", last_ready_w, 1);

        // Zero score gives class 0.
        wq[0] = 32'h04030201; bq[0] = 16'hFFF6;
        run_chain(16'h1111, 1, 1'b0, -1, c0);
        check("w_zero_score", last_ready_w, 0);

        // Three chained decisions.
        wq[0] = 32'h04030201; bq[0] = 16'hFFF7;
        wq[1] = 32'hFFFFFFFF; bq[1] = 16'h0003;
        wq[2] = 32'h00000005; bq[2] = 16'hFFFC;
        run_chain(16'h1111, 3, 1'b0, -1, c0);
        check("lat_chain_last", last_ready_cyc - c0, 3 * LAT);
        check("w_chain_last", last_ready_w, 1);

        // start during MAC with other features is ignored.
        wq[0] = 32'h01010101; bq[0] = 16'hFFF2;
        run_chain(16'h5432, 1, 1'b0, 3, c0);
        check("lat_start_ign", last_ready_cyc - c0, LAT);
        check("w_start_ign", last_ready_w, 0);

        wq[0] = 32'h04030201; bq[0] = 16'hFFF7;
        run_chain(16'h1111, 1, 1'b0, -1, c0);
        reset_mid_op();

        // Randomized chains with noisy start/stop/features and garbage weights in RESP.
        for (int t = 0; t < 40; t++) begin
            nd = int'($urandom_range(1, 4));
            f  = fvec_t'($urandom);
            for (int k = 0; k < nd; k++) begin
                wq[k] = wvec_t'($urandom);
                if ($urandom_range(0, 1) == 1)
                    bq[k] = bvec_t'($urandom);
                else
                    bq[k] = bvec_t'(int'($urandom_range(0, 2000)) - 1000);
            end
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                bus_if.stop = 1'($urandom_range(0, 1));
                next_cycle();
            end
            bus_if.stop = 1'b0;
            run_chain(f, nd, 1'b1, -1, c0);
        end

        for (int i = 0; i < 4; i++) next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
